control_unit: RTL and testbench

Multi-cycle instruction sequencer that drives the DATAPATH control interface (rs1, rs2, rd, immediate, sub, I_type, R_type, WE_RF, WE_MEM).
- Fetches 32-bit RV32I words from instruction memory over a req/ready handshake.
- Decodes the supported subset: LW, SW, ADD, SUB, ADDI.
- Issues one write strobe per instruction, then advances the PC.
- Replaces hand-driven control stimulus; the DATAPATH instance needs no changes.

---
 rtl/control_unit.sv | 143 ++++++++++++++
 tb/tb_control_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle RV32I subset sequencer (LW, SW, ADD, SUB, ADDI) driving the datapath controls
module control_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                run,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [11:0]         immediate,
  output logic                sub,
  output logic                I_type,
  output logic                R_type,
  output logic                WE_RF,
  output logic                WE_MEM,
  output logic                busy,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_TRAP
  } state_t;

  state_t              state, state_n;
  logic [PC_WIDTH-1:0] pc;
  logic [31:0]         ir;
  logic                we_rf_q, we_mem_q;

  logic        dec_legal, dec_sub, dec_i, dec_r, dec_we_rf, dec_we_mem;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [11:0] dec_imm;

  logic [6:0] op, f7;
  logic [2:0] f3;
  assign op = ir[6:0];
  assign f3 = ir[14:12];
  assign f7 = ir[31:25];

  always_comb begin
    dec_legal  = 1'b0;
    dec_sub    = 1'b0;
    dec_i      = 1'b0;
    dec_r      = 1'b0;
    dec_we_rf  = 1'b0;
    dec_we_mem = 1'b0;
    dec_rs1    = ir[19:15];
    dec_rs2    = 5'd0;
    dec_rd     = ir[11:7];
    dec_imm    = 12'd0;
    if (op == 7'b0000011 && f3 == 3'b010) begin
      dec_legal = 1'b1;
      dec_imm   = ir[31:20];
      dec_i     = 1'b1;
      dec_we_rf = 1'b1;
    end else if (op == 7'b0100011 && f3 == 3'b010) begin
      dec_legal  = 1'b1;
      dec_rd     = 5'd0;
      dec_rs2    = ir[24:20];
      dec_imm    = {ir[31:25], ir[11:7]};
      dec_i      = 1'b1;
      dec_we_mem = 1'b1;
    end else if (op == 7'b0110011 && f3 == 3'b000 &&
                 (f7 == 7'b0000000 || f7 == 7'b0100000)) begin
      dec_legal = 1'b1;
      dec_rs2   = ir[24:20];
      dec_sub   = f7[5];
      dec_r     = 1'b1;
      dec_we_rf = 1'b1;
    end else if (op == 7'b0010011 && f3 == 3'b000) begin
      dec_legal = 1'b1;
      dec_imm   = ir[31:20];
      dec_i     = 1'b1;
      dec_r     = 1'b1;
      dec_we_rf = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (run) state_n = S_FETCH;
      S_FETCH:   if (imem_ready) state_n = S_DECODE;
      S_DECODE:  state_n = dec_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: state_n = run ? S_FETCH : S_IDLE;
      S_TRAP:    state_n = S_TRAP;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  // Control fields only change on a legal decode, so they are steady through the strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc        <= RESET_PC;
      ir        <= 32'd0;
      rs1       <= 5'd0;
      rs2       <= 5'd0;
      rd        <= 5'd0;
      immediate <= 12'd0;
      sub       <= 1'b0;
      I_type    <= 1'b0;
      R_type    <= 1'b0;
      we_rf_q   <= 1'b0;
      we_mem_q  <= 1'b0;
    end else begin
      if (state == S_FETCH && imem_ready) ir <= imem_rdata;
      if (state == S_DECODE && dec_legal) begin
        rs1       <= dec_rs1;
        rs2       <= dec_rs2;
        rd        <= dec_rd;
        immediate <= dec_imm;
        sub       <= dec_sub;
        I_type    <= dec_i;
        R_type    <= dec_r;
        we_rf_q   <= dec_we_rf;
        we_mem_q  <= dec_we_mem;
      end
      if (state == S_EXECUTE) pc <= pc + PC_WIDTH'(4);
    end
  end

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign WE_RF     = (state == S_EXECUTE) && we_rf_q;
  assign WE_MEM    = (state == S_EXECUTE) && we_mem_q;
  assign busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXECUTE);
  assign illegal   = (state == S_TRAP);

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized bench for control_unit against an assembler-level reference model
module tb_control_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] immediate;
  logic        sub, I_type, R_type, WE_RF, WE_MEM, busy, illegal;

  control_unit #(.PC_WIDTH(32), .RESET_PC(32'd0)) dut (
    .CLK(CLK), .RST(RST), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate),
    .sub(sub), .I_type(I_type), .R_type(R_type),
    .WE_RF(WE_RF), .WE_MEM(WE_MEM), .busy(busy), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        legal;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic        sub, it, rt, werf, wemem;
  } exp_t;

  localparam int K_LW = 0, K_SW = 1, K_ADD = 2, K_SUB = 3, K_ADDI = 4, K_BAD = 5;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  exp_t        prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Assembler view: encode an instruction from its operands and state what the datapath should see.
  task automatic make(input int kind, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [11:0] im, output logic [31:0] w, output exp_t e);
    e = '0;
    e.legal = 1'b1;
    case (kind)
      K_LW: begin
        w = {im, s1, 3'b010, d, 7'b0000011};
        e.rd = d; e.rs1 = s1; e.imm = im; e.it = 1; e.werf = 1;
      end
      K_SW: begin
        w = {im[11:5], s2, s1, 3'b010, im[4:0], 7'b0100011};
        e.rs1 = s1; e.rs2 = s2; e.imm = im; e.it = 1; e.wemem = 1;
      end
      K_ADD, K_SUB: begin
        w = {(kind == K_SUB) ? 7'b0100000 : 7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
        e.rd = d; e.rs1 = s1; e.rs2 = s2; e.sub = (kind == K_SUB); e.rt = 1; e.werf = 1;
      end
      K_ADDI: begin
        w = {im, s1, 3'b000, d, 7'b0010011};
        e.rd = d; e.rs1 = s1; e.imm = im; e.it = 1; e.rt = 1; e.werf = 1;
      end
      default: begin
        w = {7'b0000001, s2, s1, 3'b000, d, 7'b0110011};
        e.legal = 1'b0;
      end
    endcase
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_zero"}, {imem_req, rs1, rs2, rd, immediate, sub, I_type, R_type, WE_RF, WE_MEM, busy, illegal}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
  endtask

  // Starts at a negedge in FETCH; returns at the negedge after EXECUTE (or in TRAP).
  task automatic run_instr(input logic [31:0] w, input exp_t e, input int delay, input bit drop_run);
    for (int i = 0; i <= delay; i++) begin
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", imem_addr, exp_pc);
      chk("fetch_busy", 32'(busy), 32'd1);
      chk("fetch_we", 32'({WE_RF, WE_MEM}), 32'd0);
      if (i == 0) begin
        chk("hold_rd", 32'(rd), 32'(prev.rd));
        chk("hold_imm", 32'(immediate), 32'(prev.imm));
        if (drop_run) run = 1'b0;
      end
      imem_ready = (i == delay);
      imem_rdata = (i == delay) ? w : $urandom;
      @(negedge CLK);
    end
    imem_ready = 1'($urandom);
    imem_rdata = $urandom;
    chk("dec_req", 32'(imem_req), 32'd0);
    chk("dec_busy", 32'(busy), 32'd1);
    chk("dec_we", 32'({WE_RF, WE_MEM}), 32'd0);
    chk("dec_hold_rs1", 32'(rs1), 32'(prev.rs1));
    @(negedge CLK);
    imem_ready = 1'b0;
    if (e.legal) begin
      chk("ex_rd", 32'(rd), 32'(e.rd));
      chk("ex_rs1", 32'(rs1), 32'(e.rs1));
      chk("ex_rs2", 32'(rs2), 32'(e.rs2));
      chk("ex_imm", 32'(immediate), 32'(e.imm));
      chk("ex_ctl", 32'({sub, I_type, R_type}), 32'({e.sub, e.it, e.rt}));
      chk("ex_we", 32'({WE_RF, WE_MEM}), 32'({e.werf, e.wemem}));
      chk("ex_busy", 32'({busy, illegal, imem_req}), 32'b100);
      prev = e;
      exp_pc = exp_pc + 32'd4;
      @(negedge CLK);
    end else begin
      for (int c = 0; c < 3; c++) begin
        imem_ready = 1'b1;
        chk("trap_flags", 32'({illegal, busy, imem_req}), 32'b100);
        chk("trap_we", 32'({WE_RF, WE_MEM}), 32'd0);
        chk("trap_pc", imem_addr, exp_pc);
        @(negedge CLK);
      end
      imem_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    run = 1'b0;
    #1;
    chk_zero("rst");
    @(negedge CLK);
    @(negedge CLK);
    chk_zero("rst_hold");
    RST = 1'b0;
    exp_pc = 32'd0;
    prev = '0;
    @(negedge CLK);
    chk("idle_busy", 32'({busy, imem_req}), 32'd0);
    run = 1'b1;
    @(negedge CLK);
  endtask

  logic [31:0] w;
  exp_t        e;

  initial begin
    RST = 1'b1; run = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
    exp_pc = 32'd0; prev = '0;
    @(negedge CLK);
    do_reset();

    make(K_LW, 5'd1, 5'd0, 5'd0, 12'd16, w, e);
    run_instr(w, e, 0, 1'b0);
    make(K_ADD, 5'd10, 5'd1, 5'd5, 12'd0, w, e);
    run_instr(w, e, 0, 1'b0);
    make(K_SUB, 5'd20, 5'd5, 5'd1, 12'd0, w, e);
    run_instr(w, e, 0, 1'b0);
    make(K_SW, 5'd0, 5'd0, 5'd10, 12'd10, w, e);
    run_instr(w, e, 4, 1'b0);
    make(K_ADDI, 5'd30, 5'd21, 5'd0, 12'hFCE, w, e);
    run_instr(w, e, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      make(int'($urandom_range(0, 4)), 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom), w, e);
      run_instr(w, e, int'($urandom_range(0, 3)), 1'b0);
    end

    make(K_ADD, 5'd3, 5'd4, 5'd6, 12'd0, w, e);
    run_instr(w, e, 1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      imem_ready = 1'b1;
      chk("stop_idle", 32'({busy, imem_req, WE_RF, WE_MEM}), 32'd0);
      chk("stop_pc", imem_addr, exp_pc);
      @(negedge CLK);
    end
    imem_ready = 1'b0;

    run = 1'b1;
    @(negedge CLK);
    chk("resume_req", 32'(imem_req), 32'd1);
    imem_ready = 1'b1;
    imem_rdata = 32'h00508533;
    @(negedge CLK);
    imem_ready = 1'b0;
    RST = 1'b1;
    #1;
    chk_zero("async_rst");
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      chk_zero("rst_no_we");
    end
    RST = 1'b0;
    run = 1'b0;
    exp_pc = 32'd0;
    prev = '0;
    @(negedge CLK);
    run = 1'b1;
    @(negedge CLK);

    make(K_LW, 5'd7, 5'd2, 5'd0, 12'h7FF, w, e);
    run_instr(w, e, 0, 1'b0);
    e = '0;
    run_instr(32'h00000073, e, 0, 1'b0);
    do_reset();

    make(K_ADDI, 5'd9, 5'd9, 5'd0, 12'h800, w, e);
    run_instr(w, e, 2, 1'b0);
    make(K_BAD, 5'($urandom), 5'($urandom), 5'($urandom), 12'd0, w, e);
    run_instr(w, e, 0, 1'b0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
